// File: rtl/emu_sweep_ctrl.sv
// emu_sweep_ctrl: emulator-resident sweep controller.
// Drives a fixed-point ramp START..STOP (step STEP) onto the DUT input and holds
// each point for SETTLE cycles. It then samples the DUT output against a golden
// value and accumulates the squared error. After the ramp it reports pass/fail
// against an RMS tolerance without taking a square root.
//
// Ports:
//   emu_clk, emu_rst_n : clock, synchronous active-low reset
//   start, abort       : sweep launch pulse / return-to-idle request
//   in_                : signed stimulus to the DUT
//   out, expct         : signed DUT output and golden value for current in_
//   sample_valid       : high in the cycle out/expct are captured
//   busy, done, pass   : status; pass is meaningful while done=1
//   n_samp             : samples accumulated (saturating)
//   sum_err_sqrd       : accumulated squared error in LSB^2 (saturating)
module emu_sweep_ctrl #(
    parameter int unsigned     WIDTH  = 18,
    parameter int              START  = -12,
    parameter int              STOP   = 12,
    parameter int unsigned     STEP   = 4,
    parameter int unsigned     SETTLE = 2,
    parameter int unsigned     CNT_W  = 16,
    parameter int unsigned     ACC_W  = 48,
    parameter longint unsigned TOL_SQ = 1
) (
    input  logic                    emu_clk,
    input  logic                    emu_rst_n,
    input  logic                    start,
    input  logic                    abort,
    output logic signed [WIDTH-1:0] in_,
    input  logic signed [WIDTH-1:0] out,
    input  logic signed [WIDTH-1:0] expct,
    output logic                    sample_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [CNT_W-1:0]        n_samp,
    output logic [ACC_W-1:0]        sum_err_sqrd
);

    localparam int unsigned SQ_W   = 2 * WIDTH + 2;
    localparam int unsigned SUM_W  = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;
    localparam int unsigned PROD_W = ACC_W + CNT_W;
    localparam int unsigned SET_W  = (SETTLE > 2) ? $clog2(SETTLE) : 1;

    localparam logic signed [WIDTH-1:0] START_V = WIDTH'(START);
    localparam logic signed [WIDTH-1:0] STOP_V  = WIDTH'(STOP);
    localparam logic [SET_W-1:0]        RELOAD  = SET_W'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [SET_W-1:0]        settle_cnt;
    logic                    ld_sweep, do_sample, do_check;

    logic signed [WIDTH:0]   diff;
    logic signed [SQ_W-1:0]  prod;
    logic [SQ_W-1:0]         sq;
    logic [SUM_W-1:0]        sum_ext;
    logic [ACC_W-1:0]        acc_nxt;
    logic [CNT_W-1:0]        cnt_nxt;
    logic signed [WIDTH:0]   nxt;
    logic signed [WIDTH:0]   stop_x;
    logic                    step_ok;
    logic [PROD_W-1:0]       limit;
    logic                    check_pass;

    // Squared error of the current sample, widened so that no term can overflow
    assign diff    = {expct[WIDTH-1], expct} - {out[WIDTH-1], out};
    assign prod    = SQ_W'(diff) * SQ_W'(diff);
    assign sq      = SQ_W'(prod);
    assign sum_ext = SUM_W'(sum_err_sqrd) + SUM_W'(sq);
    assign acc_nxt = (sum_ext > SUM_W'({ACC_W{1'b1}})) ? {ACC_W{1'b1}} : ACC_W'(sum_ext);
    assign cnt_nxt = (n_samp == {CNT_W{1'b1}}) ? n_samp : n_samp + CNT_W'(1);

    // Next ramp point in WIDTH+1 bits so values past the WIDTH range stop the sweep instead of wrapping
    assign nxt     = {in_[WIDTH-1], in_} + (WIDTH + 1)'(STEP);
    assign stop_x  = {STOP_V[WIDTH-1], STOP_V};
    assign step_ok = (nxt <= stop_x);

    // RMS check as sum <= n*TOL_SQ; a saturated accumulator is not trustworthy
    assign limit      = PROD_W'(n_samp) * PROD_W'(TOL_SQ);
    assign check_pass = (sum_err_sqrd != {ACC_W{1'b1}}) && (PROD_W'(sum_err_sqrd) <= limit);

    // State register
    always_ff @(posedge emu_clk) begin
        if (!emu_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        state_d   = state_q;
        ld_sweep  = 1'b0;
        do_sample = 1'b0;
        do_check  = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_SETTLE;
                    ld_sweep = 1'b1;
                end
            end
            S_SETTLE: begin
                if (settle_cnt == '0) state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                do_sample = 1'b1;
                state_d   = step_ok ? S_SETTLE : S_CHECK;
            end
            S_CHECK: begin
                do_check = 1'b1;
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d   = S_IDLE;
            ld_sweep  = 1'b0;
            do_sample = 1'b0;
            do_check  = 1'b0;
        end
    end

    // Datapath and registered status outputs
    always_ff @(posedge emu_clk) begin
        if (!emu_rst_n) begin
            in_          <= '0;
            settle_cnt   <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            n_samp       <= '0;
            sum_err_sqrd <= '0;
        end else begin
            sample_valid <= (state_d == S_SAMPLE);
            busy         <= (state_d == S_SETTLE) || (state_d == S_SAMPLE) || (state_d == S_CHECK);
            done         <= (state_d == S_DONE);

            if (abort) begin
                in_  <= '0;
                pass <= 1'b0;
            end else if (ld_sweep) begin
                in_          <= START_V;
                settle_cnt   <= RELOAD;
                pass         <= 1'b0;
                n_samp       <= '0;
                sum_err_sqrd <= '0;
            end else if (do_sample) begin
                sum_err_sqrd <= acc_nxt;
                n_samp       <= cnt_nxt;
                if (step_ok) begin
                    in_        <= nxt[WIDTH-1:0];
                    settle_cnt <= RELOAD;
                end
            end else if (do_check) begin
                pass <= check_pass;
            end else if ((state_q == S_SETTLE) && (settle_cnt != '0)) begin
                settle_cnt <= settle_cnt - SET_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_emu_sweep_ctrl.sv
// Directed bench for emu_sweep_ctrl: four instances cover the default ramp,
// the near-full-scale no-wrap ramp, and SETTLE=1 / SETTLE=5 timing.
module tb_emu_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic st [4];
    logic ab [4];
    logic signed [17:0] inv [4];
    logic signed [17:0] ot  [4];
    logic signed [17:0] ex  [4];
    logic sv [4];
    logic bz [4];
    logic dn [4];
    logic ps [4];
    logic [15:0] ns [4];
    logic [47:0] sm [4];
    int off [4];

    int vecs = 0;
    int errs = 0;

    logic signed [17:0] seen [$];
    logic [15:0] g_n1;
    logic [47:0] g_sum1;
    logic g_done1;
    logic signed [17:0] g_in1;

    int exp_ramp [7] = '{-12, -8, -4, 0, 4, 8, 12};

    for (genvar i = 0; i < 4; i++) begin : g_lb
        assign ex[i] = inv[i];
        assign ot[i] = inv[i] - 18'(off[i]);
    end

    emu_sweep_ctrl u_def (
        .emu_clk(clk), .emu_rst_n(rst_n), .start(st[0]), .abort(ab[0]),
        .in_(inv[0]), .out(ot[0]), .expct(ex[0]), .sample_valid(sv[0]),
        .busy(bz[0]), .done(dn[0]), .pass(ps[0]), .n_samp(ns[0]), .sum_err_sqrd(sm[0])
    );

    emu_sweep_ctrl #(.WIDTH(18), .START(131000), .STOP(131071), .STEP(40)) u_top (
        .emu_clk(clk), .emu_rst_n(rst_n), .start(st[1]), .abort(ab[1]),
        .in_(inv[1]), .out(ot[1]), .expct(ex[1]), .sample_valid(sv[1]),
        .busy(bz[1]), .done(dn[1]), .pass(ps[1]), .n_samp(ns[1]), .sum_err_sqrd(sm[1])
    );

    emu_sweep_ctrl #(.SETTLE(1)) u_s1 (
        .emu_clk(clk), .emu_rst_n(rst_n), .start(st[2]), .abort(ab[2]),
        .in_(inv[2]), .out(ot[2]), .expct(ex[2]), .sample_valid(sv[2]),
        .busy(bz[2]), .done(dn[2]), .pass(ps[2]), .n_samp(ns[2]), .sum_err_sqrd(sm[2])
    );

    emu_sweep_ctrl #(.SETTLE(5)) u_s5 (
        .emu_clk(clk), .emu_rst_n(rst_n), .start(st[3]), .abort(ab[3]),
        .in_(inv[3]), .out(ot[3]), .expct(ex[3]), .sample_valid(sv[3]),
        .busy(bz[3]), .done(dn[3]), .pass(ps[3]), .n_samp(ns[3]), .sum_err_sqrd(sm[3])
    );

    // Launch a sweep on instance k and follow it to done.
    // lat counts rising edges from the one that samples start; fsv is lat of the
    // first sample_valid; viol counts in_ changes not directly after a sample.
    task automatic sweep(input int k, input bit spam, output int lat, output int fsv, output int viol);
        logic signed [17:0] prev_in;
        logic prev_sv;
        seen.delete();
        lat = 0; fsv = 0; viol = 0;
        @(negedge clk);
        st[k] = 1'b1;
        @(posedge clk); #1;
        if (!spam) st[k] = 1'b0;
        lat = 1;
        g_n1 = ns[k]; g_sum1 = sm[k]; g_done1 = dn[k]; g_in1 = inv[k];
        prev_in = inv[k]; prev_sv = sv[k];
        if (sv[k]) begin fsv = 1; seen.push_back(inv[k]); end
        while (!dn[k] && lat < 500) begin
            @(posedge clk); #1;
            lat++;
            if (inv[k] !== prev_in && !prev_sv) viol++;
            if (sv[k]) begin
                if (fsv == 0) fsv = lat;
                seen.push_back(inv[k]);
            end
            prev_in = inv[k]; prev_sv = sv[k];
        end
        st[k] = 1'b0;
        if (!dn[k]) begin
            vecs++; errs++;
            $display("FAIL sweep_timeout inst %0d: done=%b after %0d edges, required 1", k, dn[k], lat);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            vecs++;
            if (inv[k] !== 18'sd0 || sv[k] !== 1'b0 || bz[k] !== 1'b0 || dn[k] !== 1'b0 ||
                ps[k] !== 1'b0 || ns[k] !== 16'd0 || sm[k] !== 48'd0) begin
                errs++;
                $display("FAIL reset_state inst %0d: in_=%0d sv=%b busy=%b done=%b pass=%b n=%0d sum=%0d, required all zero",
                         k, inv[k], sv[k], bz[k], dn[k], ps[k], ns[k], sm[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_loopback(input bit spam);
        int lat, fsv, viol;
        off[0] = 0;
        sweep(0, spam, lat, fsv, viol);
        vecs++; if (lat !== 23) begin errs++; $display("FAIL loop_latency spam=%0b: got %0d, required 23", spam, lat); end
        vecs++; if (fsv !== 3) begin errs++; $display("FAIL loop_first_sample spam=%0b: got %0d, required 3", spam, fsv); end
        vecs++; if (viol !== 0) begin errs++; $display("FAIL loop_settle_hold spam=%0b: %0d changes, required 0", spam, viol); end
        vecs++;
        if (seen.size() != 7) begin
            errs++; $display("FAIL loop_ramp_len spam=%0b: got %0d, required 7", spam, seen.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                vecs++;
                if (int'(seen[i]) != exp_ramp[i]) begin
                    errs++; $display("FAIL loop_ramp[%0d] spam=%0b: got %0d, required %0d", i, spam, seen[i], exp_ramp[i]);
                end
            end
        end
        vecs++; if (ns[0] !== 16'd7) begin errs++; $display("FAIL loop_n_samp: got %0d, required 7", ns[0]); end
        vecs++; if (sm[0] !== 48'd0) begin errs++; $display("FAIL loop_sum: got %0d, required 0", sm[0]); end
        vecs++; if (ps[0] !== 1'b1 || bz[0] !== 1'b0) begin errs++; $display("FAIL loop_pass: pass=%b busy=%b, required 1/0", ps[0], bz[0]); end
        // Results must hold in DONE
        repeat (3) @(posedge clk);
        #1;
        vecs++; if (dn[0] !== 1'b1 || ns[0] !== 16'd7 || ps[0] !== 1'b1) begin
            errs++; $display("FAIL loop_done_hold: done=%b n=%0d pass=%b, required 1/7/1", dn[0], ns[0], ps[0]);
        end
    endtask

    task automatic test_error_budget;
        int lat, fsv, viol;
        off[0] = 1;
        sweep(0, 1'b0, lat, fsv, viol);
        vecs++; if (sm[0] !== 48'd7) begin errs++; $display("FAIL err1_sum: got %0d, required 7", sm[0]); end
        vecs++; if (ps[0] !== 1'b1) begin errs++; $display("FAIL err1_pass: got %b, required 1", ps[0]); end
        off[0] = 2;
        sweep(0, 1'b0, lat, fsv, viol);
        // Restart from DONE clears the results on the first cycle
        vecs++; if (g_n1 !== 16'd0 || g_sum1 !== 48'd0 || g_done1 !== 1'b0 || g_in1 !== -18'sd12) begin
            errs++; $display("FAIL restart_clear: n=%0d sum=%0d done=%b in_=%0d, required 0/0/0/-12", g_n1, g_sum1, g_done1, g_in1);
        end
        vecs++; if (sm[0] !== 48'd28) begin errs++; $display("FAIL err2_sum: got %0d, required 28", sm[0]); end
        vecs++; if (ps[0] !== 1'b0 || dn[0] !== 1'b1) begin errs++; $display("FAIL err2_pass: pass=%b done=%b, required 0/1", ps[0], dn[0]); end
        off[0] = 0;
    endtask

    task automatic test_no_wrap;
        int lat, fsv, viol;
        sweep(1, 1'b0, lat, fsv, viol);
        vecs++; if (lat !== 8) begin errs++; $display("FAIL nowrap_latency: got %0d, required 8", lat); end
        vecs++;
        if (seen.size() != 2) begin
            errs++; $display("FAIL nowrap_len: got %0d, required 2", seen.size());
        end else if (int'(seen[0]) != 131000 || int'(seen[1]) != 131040) begin
            errs++; $display("FAIL nowrap_values: got %0d,%0d, required 131000,131040", seen[0], seen[1]);
        end
        vecs++; if (ns[1] !== 16'd2 || ps[1] !== 1'b1) begin errs++; $display("FAIL nowrap_n: n=%0d pass=%b, required 2/1", ns[1], ps[1]); end
        vecs++; if (int'(inv[1]) != 131040) begin errs++; $display("FAIL nowrap_in_hold: got %0d, required 131040", inv[1]); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        vecs++; if (inv[0] !== -18'sd4 || bz[0] !== 1'b1) begin
            errs++; $display("FAIL midreset_pre: in_=%0d busy=%b, required -4/1", inv[0], bz[0]);
        end
        @(negedge clk);
        rst_n = 1'b0;
        st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        vecs++; if (inv[0] !== 18'sd0 || sv[0] !== 1'b0 || bz[0] !== 1'b0 || dn[0] !== 1'b0 ||
                    ps[0] !== 1'b0 || ns[0] !== 16'd0 || sm[0] !== 48'd0) begin
            errs++; $display("FAIL midreset_state: in_=%0d sv=%b busy=%b done=%b pass=%b n=%0d sum=%0d, required all zero",
                             inv[0], sv[0], bz[0], dn[0], ps[0], ns[0], sm[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_abort;
        int nsv, t;
        off[0] = 1;
        nsv = 0; t = 0;
        @(negedge clk);
        st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        // Abort on the second sample: only the first sample's error is kept
        while (nsv < 2 && t < 100) begin
            @(posedge clk); #1;
            t++;
            if (sv[0]) nsv++;
        end
        ab[0] = 1'b1;
        @(posedge clk); #1;
        ab[0] = 1'b0;
        vecs++; if (bz[0] !== 1'b0 || dn[0] !== 1'b0 || inv[0] !== 18'sd0 || sv[0] !== 1'b0 || ps[0] !== 1'b0) begin
            errs++; $display("FAIL abort_idle: busy=%b done=%b in_=%0d sv=%b pass=%b, required 0/0/0/0/0", bz[0], dn[0], inv[0], sv[0], ps[0]);
        end
        vecs++; if (ns[0] !== 16'd1 || sm[0] !== 48'd1) begin
            errs++; $display("FAIL abort_hold: n=%0d sum=%0d, required 1/1", ns[0], sm[0]);
        end
        // abort wins over start in the same cycle
        @(negedge clk);
        st[0] = 1'b1; ab[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0; ab[0] = 1'b0;
        vecs++; if (bz[0] !== 1'b0 || inv[0] !== 18'sd0) begin
            errs++; $display("FAIL abort_start: busy=%b in_=%0d, required 0/0", bz[0], inv[0]);
        end
        @(posedge clk); #1;
        vecs++; if (bz[0] !== 1'b0 || ns[0] !== 16'd1) begin
            errs++; $display("FAIL abort_start_idle: busy=%b n=%0d, required 0/1", bz[0], ns[0]);
        end
        off[0] = 0;
    endtask

    task automatic test_settle_timing;
        int lat, fsv, viol;
        sweep(2, 1'b0, lat, fsv, viol);
        vecs++; if (fsv !== 2) begin errs++; $display("FAIL s1_first_sample: got %0d, required 2", fsv); end
        vecs++; if (lat !== 16) begin errs++; $display("FAIL s1_latency: got %0d, required 16", lat); end
        vecs++; if (viol !== 0 || ns[2] !== 16'd7) begin errs++; $display("FAIL s1_hold: viol=%0d n=%0d, required 0/7", viol, ns[2]); end
        sweep(3, 1'b0, lat, fsv, viol);
        vecs++; if (fsv !== 6) begin errs++; $display("FAIL s5_first_sample: got %0d, required 6", fsv); end
        vecs++; if (lat !== 44) begin errs++; $display("FAIL s5_latency: got %0d, required 44", lat); end
        vecs++; if (viol !== 0 || ns[3] !== 16'd7) begin errs++; $display("FAIL s5_hold: viol=%0d n=%0d, required 0/7", viol, ns[3]); end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            st[k] = 1'b0; ab[k] = 1'b0; off[k] = 0;
        end
        test_reset();
        test_loopback(1'b0);
        test_error_budget();
        test_no_wrap();
        test_loopback(1'b1);
        test_reset_mid();
        test_abort();
        test_settle_timing();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
